// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Round-robin pick: on a tie the requester that did not win last time goes next.
  function automatic arb_owner_t arb_pick(input logic if_req, input logic d_req,
                                          input arb_owner_t last_owner);
    if (if_req && d_req) begin
      return (last_owner == OWN_D) ? OWN_IF : OWN_D;
    end else if (d_req) begin
      return OWN_D;
    end else begin
      return OWN_IF;
    end
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Bus watchdog: counts un-acked BUSY cycles; expired flags the last allowed cycle.
// No backpressure; clr has priority over inc.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // This increment brings the count to TIMEOUT, so the transaction is abandoned now.
  assign expired = inc && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; round-robin on ties, one txn in flight.
// Grant is combinational, mem_req from next cycle, rvalid one cycle after ack or timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,

  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state;
  arb_owner_t owner;
  arb_owner_t last_owner;
  arb_owner_t pick;
  logic       grant;
  logic       busy_inc;
  logic       expired;

  always_comb begin
    pick   = arb_pick(if_req, d_req, last_owner);
    grant  = (state == ST_IDLE) && (if_req || d_req);
    if_gnt = grant && (pick == OWN_IF);
    d_gnt  = grant && (pick == OWN_D);
  end

  assign busy_inc = (state == ST_BUSY) && !mem_ack;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant),
    .inc     (busy_inc),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_D;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state      <= ST_BUSY;
            owner      <= pick;
            last_owner <= pick;
            mem_req    <= 1'b1;
            if (pick == OWN_D) begin
              mem_we    <= d_we;
              mem_be    <= d_be;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_be    <= '1;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        ST_BUSY: begin
          // An ack in the final watchdog cycle still completes normally.
          if (mem_ack || expired) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            if (owner == OWN_D) begin
              d_rvalid <= 1'b1;
              d_err    <= !mem_ack;
              d_rdata  <= mem_ack ? mem_rdata : '0;
            end else begin
              if_rvalid <= 1'b1;
              if_err    <= !mem_ack;
              if_rdata  <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus scoreboard of completions.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        ifr;
    logic        dr;
    logic [31:0] ia;
    logic [31:0] da;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    int          ack_dly;   // BUSY cycles before ack; -1 = never ack
    logic [31:0] ack_dat;
    logic        exp_d;     // expected winner: 1 = data, 0 = fetch
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        own_d;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ifr, input logic dr, input logic [31:0] ia,
                              input logic [31:0] da, input logic we, input logic [3:0] be,
                              input logic [31:0] wd, input int dly, input logic [31:0] dat,
                              input logic exp_d, input logic [31:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.ifr = ifr; v.dr = dr; v.ia = ia; v.da = da; v.we = we; v.be = be; v.wd = wd;
    v.ack_dly = dly; v.ack_dat = dat; v.exp_d = exp_d;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Starts #1 after a rising edge; returns #1 after the edge that shows rvalid.
  task automatic run(input vec_t v, input int idx);
    exp_t        e;
    int          cnt;
    int          exp_cnt;
    bit          seen;
    logic [31:0] ea, ewd;
    logic        ewe;
    logic [3:0]  ebe;

    if_req = v.ifr; if_addr = v.ia;
    d_req = v.dr; d_addr = v.da; d_we = v.we; d_be = v.be; d_wdata = v.wd;
    @(negedge clk);
    chk($sformatf("v%0d if_gnt", idx), 32'(if_gnt), 32'(!v.exp_d));
    chk($sformatf("v%0d d_gnt", idx), 32'(d_gnt), 32'(v.exp_d));
    e.own_d = v.exp_d; e.rdata = v.exp_rdata; e.err = v.exp_err;
    e.chk_rdata = !(v.exp_d && v.we);
    sb.push_back(e);
    if (v.exp_d) begin
      ea = v.da; ewe = v.we; ebe = v.be; ewd = v.wd;
    end else begin
      ea = v.ia; ewe = 1'b0; ebe = 4'hF; ewd = 32'h0;
    end

    @(posedge clk); #1;
    // Winner drops its request and scrambles its fields; the loser keeps holding.
    if (v.exp_d) begin
      d_req = 1'b0; d_addr = ~v.da; d_we = ~v.we; d_be = ~v.be; d_wdata = ~v.wd;
    end else begin
      if_req = 1'b0; if_addr = ~v.ia;
    end

    cnt = 0; seen = 0;
    for (int k = 1; k <= TO + 4; k++) begin
      if (if_rvalid || d_rvalid) begin
        seen = 1;
        break;
      end
      if (mem_req) cnt++;
      if (k == 1) begin
        chk($sformatf("v%0d mem_addr", idx), mem_addr, ea);
        chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(ewe));
        chk($sformatf("v%0d mem_be", idx), 32'(mem_be), 32'(ebe));
        chk($sformatf("v%0d mem_wdata", idx), mem_wdata, ewd);
        chk($sformatf("v%0d gnt_while_busy", idx), 32'(if_gnt | d_gnt), 32'h0);
      end
      if (k == v.ack_dly + 1) begin
        mem_ack = 1'b1; mem_rdata = v.ack_dat;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
    end

    exp_cnt = (v.ack_dly >= 0) ? v.ack_dly + 1 : TO;
    chk($sformatf("v%0d rvalid_seen", idx), 32'(seen), 32'h1);
    chk($sformatf("v%0d mem_req_cycles", idx), cnt, exp_cnt);
    e = sb.pop_front();
    if (seen) begin
      chk($sformatf("v%0d mem_req_idle", idx), 32'(mem_req), 32'h0);
      chk($sformatf("v%0d d_rvalid", idx), 32'(d_rvalid), 32'(e.own_d));
      chk($sformatf("v%0d if_rvalid", idx), 32'(if_rvalid), 32'(!e.own_d));
      chk($sformatf("v%0d err", idx), 32'(e.own_d ? d_err : if_err), 32'(e.err));
      if (e.chk_rdata)
        chk($sformatf("v%0d rdata", idx), e.own_d ? d_rdata : if_rdata, e.rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Ties right after reset: fetch, data (store), fetch.
    vecs.push_back(mk(1, 1, 32'h40, 32'h2000, 1, 4'b0011, 32'hDEADBEEF, 0, 32'h11, 0, 32'h11, 0));
    vecs.push_back(mk(1, 1, 32'h44, 32'h2000, 1, 4'b0011, 32'hDEADBEEF, 0, 32'h0, 1, 32'h0, 0));
    vecs.push_back(mk(1, 1, 32'h48, 32'h2004, 0, 4'hF, 32'h0, 0, 32'h22, 0, 32'h22, 0));
    // Fetch only, ack in the second BUSY cycle.
    vecs.push_back(mk(1, 0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 1, 32'h00000013, 0, 32'h00000013, 0));
    // Continuous contention: grants alternate starting with data.
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(1, 1, 32'h200 + 32'(4 * i), 32'h3000 + 32'(4 * i), i[0], 4'hF,
                        32'h01010101 * 32'(i), i % 3, 32'hA000 + 32'(i),
                        (i % 2) == 0, 32'hA000 + 32'(i), 0));
    end
    // Dead target, then ack in the last allowed cycle, then fetch with late ack.
    vecs.push_back(mk(0, 1, 32'h0, 32'h4000, 0, 4'hF, 32'h0, -1, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 1, 32'h0, 32'h4004, 0, 4'hF, 32'h0, TO - 1, 32'hCAFE0001, 1, 32'hCAFE0001, 0));
    vecs.push_back(mk(1, 0, 32'h600, 32'h0, 0, 4'h0, 32'h0, 2, 32'h00000005, 0, 32'h00000005, 0));

    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_req", 32'(mem_req), 32'h0);
    chk("rst mem_we", 32'(mem_we), 32'h0);
    chk("rst mem_be", 32'(mem_be), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst rvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
    chk("rst err", 32'({if_err, d_err}), 32'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

    // Spurious ack while idle must not produce a completion.
    if_req = 1'b0; d_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("spurious rvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
    chk("spurious mem_req", 32'(mem_req), 32'h0);

    // Reset while a fetch is in flight: silent abort, arbitration state restored.
    if_req = 1'b1; if_addr = 32'h500;
    @(negedge clk);
    chk("abort if_gnt", 32'(if_gnt), 32'h1);
    @(posedge clk); #1;
    if_req = 1'b0;
    chk("abort mem_req busy", 32'(mem_req), 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort mem_req", 32'(mem_req), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort no_rvalid %0d", i), 32'({if_rvalid, d_rvalid}), 32'h0);
      @(posedge clk); #1;
    end
    run(mk(1, 1, 32'h700, 32'h5000, 0, 4'hF, 32'h0, 0, 32'h77, 0, 32'h77, 0), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing one memory port between the RV32I core's instruction-fetch path and its load/store path. Accepts one request at a time, drives a single outstanding transaction on the memory port, and returns completion, read data and error to the owning requester. Fair round-robin on contention and a bus-timeout watchdog so a dead target cannot hang the core.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (byte enables are `DATA_W/8`)
- `TIMEOUT`, 255, max cycles `mem_req` may wait for `mem_ack`; must be ≥ 1

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted (1-cycle pulse)
- `if_rvalid`  out  1  fetch completion (1-cycle pulse)
- `if_rdata`  out  DATA_W  fetch data, valid with `if_rvalid`
- `if_err`  out  1  fetch timed out, valid with `if_rvalid`
- `d_req`  in  1  data request; held with all `d_*` fields until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_be`  in  DATA_W/8  byte enables
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`  out  1/1/DATA_W/1  same semantics as the `if_*` outputs
- `mem_req`  out  1  transaction pending on memory port
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/DATA_W/8/ADDR_W/DATA_W  registered transaction fields
- `mem_ack`  in  1  target completes transaction this cycle
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`

## Operation
- States: `IDLE`, `BUSY`. Owner register (`IF`/`D`) and `last_owner` register.
- IDLE: if exactly one `*_req` is high, grant it. If both are high, grant the one not equal to `last_owner`. A grant pulses `*_gnt` combinationally in the same cycle, latches the fields into `mem_*`, sets owner and `last_owner`, and moves to BUSY.
- Fetch grant drives `mem_we=0`, `mem_be='1`, `mem_wdata=0`.
- BUSY: `mem_req=1`, and `mem_*` stay stable. On `mem_ack`: latch `mem_rdata`, pulse the owner's `*_rvalid` next cycle with `*_err=0`, return to IDLE. Stores also complete through `rvalid`, and their `rdata` is don't-care.
- Timeout: a counter clears on grant and increments each BUSY cycle without `mem_ack`. When it reaches `TIMEOUT`, drop `mem_req`, pulse the owner's `rvalid` with `err=1` and `rdata=0`, and return to IDLE.
- `mem_ack` in the same cycle the counter hits `TIMEOUT` takes priority, so the transaction completes normally.
- `mem_ack` while IDLE is ignored.
- No grant is issued while BUSY, including when `*_req` is high; requesters keep holding.

## Timing
- Reset values (`rst=0` at a clock edge): state `IDLE`, `last_owner=D` (so fetch wins the first tie).
- All outputs reset to 0: `mem_req`, `mem_*` fields, `*_rvalid`, `*_err`, `*_rdata`, and the counter.
- Reset mid-transaction aborts silently: `mem_req` is 0 next cycle and no `rvalid` is issued.
- Grant at cycle T puts `mem_req` high from T+1.
- With `mem_ack` at cycle A, `rvalid` is at A+1 and IDLE is at A+1. A new grant is possible at A+1, so peak throughput is one transaction per 2 cycles.
- Timeout: with grant at T and no ack, `mem_req` is high for cycles T+1..T+TIMEOUT, and `rvalid`+`err` pulse at T+TIMEOUT+1.
- `*_gnt` depends combinationally on `*_req` and the registered state only. All other outputs are registered.

## Structure
- Package `mem_arb_pkg`: `typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t`, `typedef enum logic {OWN_IF, OWN_D} arb_owner_t`, and the default `TIMEOUT` constant.
- One sub-module, `mem_arb_timer`: a clearable up-counter with a `TIMEOUT`-compare `expired` output, width `$clog2(TIMEOUT+1)`.

## Test plan
- Fetch only: `if_req=1`, `if_addr=0x100`, ack 2 cycles after `mem_req` with `0x00000013` → `if_gnt` at T, `mem_addr=0x100` from T+1, `if_rvalid=1`, `if_rdata=0x00000013`, `if_err=0` at T+3.
- Simultaneous requests after reset, each with immediate ack → fetch granted first, data granted second, then fetch. Verify `mem_we`/`mem_be`/`mem_wdata` for a store with `d_be=4'b0011`, `d_wdata=0xDEADBEEF`.
- Both requesters continuously requesting for 10 transactions → grants strictly alternate; `mem_req` never high while IDLE.
- `TIMEOUT=4`, no ack → `mem_req` high exactly 4 cycles, `d_rvalid=1`, `d_err=1`, `d_rdata=0`. Ack arriving in the 4th cycle instead → normal completion, `err=0`.
- `rst=0` while BUSY → next cycle `mem_req=0`, no `rvalid`, and the next tie is won by fetch. A spurious `mem_ack` while IDLE produces no `rvalid`.
